// File: rtl/regf_desc_fetch_bank.sv
// Byte-addressed register bank shared by a host port and a descriptor fetch engine that
// snapshots DESC_BYTES bytes from a pointer and offers decoded command fields over valid/ready.
module regf_desc_fetch_bank #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned DESC_BYTES = 8
) (
    input  logic              i_regf_clk,
    input  logic              i_regf_rst_n,
    input  logic              i_regf_wr_en,
    input  logic              i_regf_rd_en,
    input  logic [ADDR_W-1:0] i_regf_addr,
    input  logic [7:0]        i_regf_data_wr,
    output logic [7:0]        o_regf_data_rd,
    output logic              o_regf_rd_valid,
    output logic              o_regf_addr_err,
    input  logic              i_desc_req,
    input  logic [ADDR_W-1:0] i_desc_ptr,
    output logic              o_desc_busy,
    output logic              o_desc_valid,
    input  logic              i_desc_ready,
    output logic [2:0]        o_cccnt_CMD_ATTR,
    output logic [3:0]        o_engine_TID,
    output logic [7:0]        o_ccc_CMD,
    output logic              o_engine_CP,
    output logic [4:0]        o_cccnt_DEV_INDEX,
    output logic [2:0]        o_engine_MODE,
    output logic              o_cccnt_RnW,
    output logic              o_cccnt_WROC,
    output logic              o_cccnt_TOC,
    output logic [15:0]       o_frmcnt_data_len,
    output logic [2:0]        o_frmcnt_DTT
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [63:0]        shadow_q;
    logic [2:0]         k_q;
    logic [IDX_W-1:0]   fetch_idx_q;
    logic [IDX_W-1:0]   fetch_idx_nxt;
    logic [IDX_W-1:0]   host_idx;
    logic [IDX_W-1:0]   ptr_idx;
    logic               host_access;
    logic               in_range;
    logic               capture;
    logic               last_byte;
    logic [7:0]         rd_data_q;
    logic               rd_valid_q;
    logic               addr_err_q;

    assign host_access   = i_regf_wr_en | i_regf_rd_en;
    assign in_range      = (32'(i_regf_addr) < DEPTH);
    assign host_idx      = IDX_W'(i_regf_addr);
    assign ptr_idx       = IDX_W'(32'(i_desc_ptr) % DEPTH);
    assign last_byte     = (k_q == 3'(DESC_BYTES - 1));
    // Fetch address walks forward and wraps at DEPTH, which need not be a power of two.
    assign fetch_idx_nxt = (32'(fetch_idx_q) == DEPTH - 1) ? '0 : fetch_idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_desc_req) state_d = StFetch;
            end
            StFetch: begin
                // Any host access owns the memory this cycle, so the capture stalls.
                if (!host_access) begin
                    capture = 1'b1;
                    if (last_byte) state_d = StHold;
                end
            end
            StHold: begin
                if (i_desc_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
        if (!i_regf_rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            fetch_idx_q <= '0;
            shadow_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && i_desc_req) begin
                fetch_idx_q <= ptr_idx;
                k_q         <= '0;
            end else if (capture) begin
                shadow_q[{k_q, 3'b000} +: 8] <= mem_q[fetch_idx_q];
                fetch_idx_q                  <= fetch_idx_nxt;
                k_q                          <= k_q + 3'd1;
            end
        end
    end

    always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
        if (!i_regf_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
        end else if (i_regf_wr_en && in_range) begin
            mem_q[host_idx] <= i_regf_data_wr;
        end
    end

    // A combined read+write is treated as a write only.
    always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
        if (!i_regf_rst_n) begin
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_valid_q <= i_regf_rd_en & ~i_regf_wr_en;
            addr_err_q <= host_access & ~in_range;
            if (i_regf_rd_en && !i_regf_wr_en) begin
                rd_data_q <= in_range ? mem_q[host_idx] : 8'h00;
            end
        end
    end

    assign o_regf_data_rd    = rd_data_q;
    assign o_regf_rd_valid   = rd_valid_q;
    assign o_regf_addr_err   = addr_err_q;
    assign o_desc_busy       = (state_q != StIdle);
    assign o_desc_valid      = (state_q == StHold);

    assign o_cccnt_CMD_ATTR  = shadow_q[2:0];
    assign o_engine_TID      = shadow_q[6:3];
    assign o_ccc_CMD         = shadow_q[14:7];
    assign o_engine_CP       = shadow_q[15];
    assign o_cccnt_DEV_INDEX = shadow_q[20:16];
    assign o_engine_MODE     = shadow_q[28:26];
    assign o_cccnt_RnW       = shadow_q[29];
    assign o_cccnt_WROC      = shadow_q[30];
    assign o_cccnt_TOC       = shadow_q[31];
    assign o_frmcnt_data_len = shadow_q[47:32];
    assign o_frmcnt_DTT      = shadow_q[50:48];

    // Reserved descriptor bits are fetched but never decoded.
    logic unused_reserved;
    assign unused_reserved = ^{shadow_q[63:51], shadow_q[25:21]};

endmodule

// File: tb/tb_regf_desc_fetch_bank.sv
// Randomised bench for regf_desc_fetch_bank: a byte-array/queue model predicts every output
// each cycle, with directed scenarios pinning latency, wrap, stall, handshake and reset.
module tb_regf_desc_fetch_bank;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2048;
    localparam int DB     = 8;
    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_HOLD = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic wr_en = 1'b0, rd_en = 1'b0, req = 1'b0, ready = 1'b0;
    logic [ADDR_W-1:0] addr = '0, ptr = '0;
    logic [7:0] wdata = '0, rdata;
    logic rd_valid, addr_err, busy, valid;
    logic [2:0] attr, mode, dtt;
    logic [3:0] tid;
    logic [7:0] cmd;
    logic cp, rnw, wroc, toc;
    logic [4:0] dev;
    logic [15:0] len;

    int checks = 0, errors = 0;

    // Behavioural model
    logic [7:0] mem_m [DEPTH];
    logic [7:0] snap [DB];
    int pend[$];
    int base, phase;
    logic rdv_m, err_m;
    logic [7:0] rdd_m;

    regf_desc_fetch_bank #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DESC_BYTES(DB)) dut (
        .i_regf_clk(clk), .i_regf_rst_n(rst_n), .i_regf_wr_en(wr_en), .i_regf_rd_en(rd_en),
        .i_regf_addr(addr), .i_regf_data_wr(wdata), .o_regf_data_rd(rdata),
        .o_regf_rd_valid(rd_valid), .o_regf_addr_err(addr_err), .i_desc_req(req),
        .i_desc_ptr(ptr), .o_desc_busy(busy), .o_desc_valid(valid), .i_desc_ready(ready),
        .o_cccnt_CMD_ATTR(attr), .o_engine_TID(tid), .o_ccc_CMD(cmd), .o_engine_CP(cp),
        .o_cccnt_DEV_INDEX(dev), .o_engine_MODE(mode), .o_cccnt_RnW(rnw),
        .o_cccnt_WROC(wroc), .o_cccnt_TOC(toc), .o_frmcnt_data_len(len), .o_frmcnt_DTT(dtt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        for (int k = 0; k < DB; k++) snap[k] = 8'h00;
        pend.delete();
        phase = PH_IDLE;
        base  = 0;
        rdv_m = 1'b0;
        err_m = 1'b0;
        rdd_m = 8'h00;
    endtask

    task automatic model_update();
        bit access, inr;
        int k;
        access = wr_en | rd_en;
        inr    = (int'(addr) < DEPTH);
        case (phase)
            PH_IDLE: if (req) begin
                base = int'(ptr) % DEPTH;
                for (int j = 0; j < DB; j++) pend.push_back(j);
                phase = PH_FETCH;
            end
            PH_FETCH: if (!access) begin
                k = pend.pop_front();
                snap[k] = mem_m[(base + k) % DEPTH];
                if (pend.size() == 0) phase = PH_HOLD;
            end
            default: if (ready) phase = PH_IDLE;
        endcase
        err_m = access && !inr;
        rdv_m = rd_en && !wr_en;
        if (wr_en) begin
            if (inr) mem_m[addr] = wdata;
        end else if (rd_en) begin
            rdd_m = inr ? mem_m[addr] : 8'h00;
        end
    endtask

    task automatic compare_all();
        logic [63:0] w;
        for (int k = 0; k < DB; k++) w[8*k +: 8] = snap[k];
        chk("busy", 64'(busy), 64'(phase != PH_IDLE));
        chk("valid", 64'(valid), 64'(phase == PH_HOLD));
        chk("rd_valid", 64'(rd_valid), 64'(rdv_m));
        chk("addr_err", 64'(addr_err), 64'(err_m));
        if (rdv_m) chk("rd_data", 64'(rdata), 64'(rdd_m));
        chk("attr", 64'(attr), 64'(w[2:0]));
        chk("tid", 64'(tid), 64'(w[6:3]));
        chk("cmd", 64'(cmd), 64'(w[14:7]));
        chk("cp", 64'(cp), 64'(w[15]));
        chk("dev", 64'(dev), 64'(w[20:16]));
        chk("mode", 64'(mode), 64'(w[28:26]));
        chk("rnw_wroc_toc", 64'({rnw, wroc, toc}), 64'({w[29], w[30], w[31]}));
        chk("len", 64'(len), 64'(w[47:32]));
        chk("dtt", 64'(dtt), 64'(w[50:48]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1 rst_n = 1'b1;
    endtask

    task automatic host_wr(input int a, input logic [7:0] d);
        wr_en = 1'b1; addr = ADDR_W'(a); wdata = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic host_rd(input int a);
        rd_en = 1'b1; addr = ADDR_W'(a);
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic start_fetch(input int p);
        req = 1'b1; ptr = ADDR_W'(p);
        cyc();
        req = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!valid && edges < 40) begin
            cyc();
            edges++;
        end
        chk("wait_valid", 64'(valid), 64'd1);
    endtask

    task automatic accept();
        ready = 1'b1;
        cyc();
        ready = 1'b0;
    endtask

    int n;
    int sel, a;
    logic [7:0] bytes1 [8] = '{8'hf1, 8'h8f, 8'h10, 8'h18, 8'h00, 8'h01, 8'h03, 8'h00};
    logic [7:0] bytes2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    initial begin
        model_reset();
        #3;
        compare_all();
        #4 rst_n = 1'b1;

        // Basic decode
        for (int i = 0; i < 8; i++) host_wr(1000 + i, bytes1[i]);
        start_fetch(1000);
        wait_valid(n);
        chk("latency", 64'(n), 64'd8);
        chk("lit_attr", 64'(attr), 64'd1);
        chk("lit_tid", 64'(tid), 64'hE);
        chk("lit_cmd", 64'(cmd), 64'h1F);
        chk("lit_cp", 64'(cp), 64'd1);
        chk("lit_dev", 64'(dev), 64'd16);
        chk("lit_mode", 64'(mode), 64'd6);
        chk("lit_rwt", 64'({rnw, wroc, toc}), 64'd0);
        chk("lit_len", 64'(len), 64'd256);
        chk("lit_dtt", 64'(dtt), 64'd3);
        accept();
        chk("lit_valid_drop", 64'(valid), 64'd0);

        // Wrap across the top of memory
        for (int i = 0; i < 8; i++) host_wr((2044 + i) % DEPTH, bytes2[i]);
        start_fetch(2044);
        wait_valid(n);
        chk("wrap_len", 64'(len), 64'h6655);
        chk("wrap_dev", 64'(dev), 64'h13);
        chk("wrap_dtt", 64'(dtt), 64'd7);
        accept();

        // Stall while byte 6 pending, then snapshot immunity
        start_fetch(1000);
        repeat (6) cyc();
        host_wr(1007, 8'h05);
        wait_valid(n);
        chk("latency_stall", 64'(7 + n), 64'd9);
        host_wr(1000, 8'h00);
        chk("snap_attr", 64'(attr), 64'd1);
        chk("snap_tid", 64'(tid), 64'hE);
        accept();

        // Backpressure with an ignored request
        start_fetch(1000);
        wait_valid(n);
        repeat (2) cyc();
        req = 1'b1; ptr = ADDR_W'(2044);
        cyc();
        req = 1'b0;
        repeat (2) cyc();
        chk("hold_valid", 64'(valid), 64'd1);
        accept();
        chk("hold_drop", 64'(valid), 64'd0);
        start_fetch(2044);
        chk("new_req_busy", 64'(busy), 64'd1);
        wait_valid(n);
        accept();

        // Out-of-range and combined access
        host_wr(3000, 8'h5A);
        chk("oor_wr_err", 64'(addr_err), 64'd1);
        host_rd(3000);
        chk("oor_rd", 64'({rd_valid, addr_err, rdata}), 64'h300);
        rd_en = 1'b1;
        host_wr(10, 8'h77);
        rd_en = 1'b0;
        chk("rdwr_no_read", 64'(rd_valid), 64'd0);
        host_rd(10);
        chk("rdwr_data", 64'(rdata), 64'h77);

        // Reset mid-fetch
        start_fetch(1000);
        repeat (3) cyc();
        do_reset();
        chk("rst_busy_valid", 64'({busy, valid}), 64'd0);
        chk("rst_fields", 64'({attr, tid, cmd, dev, len}), 64'd0);
        start_fetch(1000);
        wait_valid(n);
        chk("refetch_zero", 64'({attr, tid, cmd, cp, dev, mode, rnw, wroc, toc, len, dtt}), 64'd0);
        accept();
        host_rd(1000);
        chk("mem_cleared", 64'(rdata), 64'd0);

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: a = 2040 + $urandom_range(0, 7);
                1: a = $urandom_range(0, 7);
                2: a = 1000 + $urandom_range(0, 10);
                default: a = 2048 + $urandom_range(0, 2047);
            endcase
            n = $urandom_range(0, 99);
            wr_en = (n < 12) || (n >= 25 && n < 28);
            rd_en = (n >= 12 && n < 28);
            addr  = ADDR_W'(a);
            wdata = 8'($urandom);
            req   = ($urandom_range(0, 4) == 0);
            ptr   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'(2040 + $urandom_range(0, 15));
            ready = $urandom_range(0, 1) == 1;
            cyc();
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        wr_en = 1'b0; rd_en = 1'b0; req = 1'b0; ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
